// File: rtl/gpio_message_receiver.sv
// gpio_message_receiver: reassembles a multi-beat message from a remote
// transmitter over an asynchronous four-phase req/ack GPIO link.
//
// Ports:
//   clock          system clock, rising-edge
//   resetn         asynchronous active-low reset
//   link_req       transmitter request (asynchronous, synchronized here)
//   link_data      16-bit beat payload, bundled with link_req
//   link_ack       acknowledge back to the transmitter
//   message_out    last complete message, beat 0 in the MSBs
//   message_valid  one-cycle pulse when message_out updates
//   busy           message partially received or flush in progress
//   error          one-cycle pulse on timeout abort
module gpio_message_receiver #(
    parameter int BEATS          = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  link_req,
    input  logic [15:0]           link_data,
    output logic                  link_ack,
    output logic [16*BEATS-1:0]   message_out,
    output logic                  message_valid,
    output logic                  busy,
    output logic                  error
);

    localparam int W  = 16 * BEATS;
    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int IW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
    localparam logic [IW-1:0] IDLE_MAX  = IW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_HI = 2'd0,
        WAIT_LO = 2'd1,
        FLUSH   = 2'd2
    } state_t;

    state_t          state, state_n;
    logic            req_m, req_s;
    logic [CW-1:0]   beat_cnt, beat_n;
    logic [IW-1:0]   idle_cnt, idle_n;
    logic [W-1:0]    shreg, shreg_n;
    logic [W-1:0]    msg_n;
    logic            ack_n;
    logic            valid_n;
    logic            error_n;
    logic            counting;
    logic            expired;

    // Two-flop synchronizer for the asynchronous request.
    // link_data is not synchronized: it is held stable by the
    // transmitter until link_ack is seen high.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            req_m <= 1'b0;
            req_s <= 1'b0;
        end else begin
            req_m <= link_req;
            req_s <= req_m;
        end
    end

    // Idle timer runs whenever the link owes us a handshake event
    // inside a message.
    assign counting = (state == WAIT_LO) ||
                      ((state == WAIT_HI) && (beat_cnt != '0));
    assign expired  = counting && (idle_cnt == IDLE_MAX);

    always_comb begin
        state_n = state;
        ack_n   = link_ack;
        beat_n  = beat_cnt;
        shreg_n = shreg;
        msg_n   = message_out;
        valid_n = 1'b0;
        error_n = 1'b0;

        unique case (state)
            WAIT_HI: begin
                if (req_s) begin
                    // Beat 0 ends up in the MSBs after BEATS shifts.
                    shreg_n = (shreg << 16) | W'(link_data);
                    ack_n   = 1'b1;
                    state_n = WAIT_LO;
                end else if (expired) begin
                    // req_s is low here, so no flush is needed.
                    ack_n   = 1'b0;
                    beat_n  = '0;
                    shreg_n = '0;
                    error_n = 1'b1;
                    state_n = WAIT_HI;
                end
            end
            WAIT_LO: begin
                if (!req_s) begin
                    ack_n   = 1'b0;
                    state_n = WAIT_HI;
                    if (beat_cnt == LAST_BEAT) begin
                        msg_n   = shreg;
                        valid_n = 1'b1;
                        beat_n  = '0;
                    end else begin
                        beat_n = beat_cnt + CW'(1);
                    end
                end else if (expired) begin
                    // Transmitter still holds req high: drain it
                    // in FLUSH so the stuck beat is not captured.
                    ack_n   = 1'b0;
                    beat_n  = '0;
                    shreg_n = '0;
                    error_n = 1'b1;
                    state_n = FLUSH;
                end
            end
            FLUSH: begin
                ack_n = 1'b0;
                if (!req_s) begin
                    beat_n  = '0;
                    state_n = WAIT_HI;
                end
            end
            default: begin
                ack_n   = 1'b0;
                beat_n  = '0;
                state_n = WAIT_HI;
            end
        endcase

        // Cleared on any state change or abort, held at zero while
        // not counting, never allowed to wrap.
        if ((state_n != state) || expired || !counting) begin
            idle_n = '0;
        end else begin
            idle_n = idle_cnt + IW'(1);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state         <= WAIT_HI;
            link_ack      <= 1'b0;
            beat_cnt      <= '0;
            idle_cnt      <= '0;
            shreg         <= '0;
            message_out   <= '0;
            message_valid <= 1'b0;
            error         <= 1'b0;
        end else begin
            state         <= state_n;
            link_ack      <= ack_n;
            beat_cnt      <= beat_n;
            idle_cnt      <= idle_n;
            shreg         <= shreg_n;
            message_out   <= msg_n;
            message_valid <= valid_n;
            error         <= error_n;
        end
    end

    assign busy = (beat_cnt != '0) || (state == WAIT_LO) || (state == FLUSH);

endmodule

// File: tb/tb_gpio_message_receiver.sv
// tb_gpio_message_receiver: directed + randomized handshake stimulus
// against a beat-placement reference model for gpio_message_receiver.
module tb_gpio_message_receiver;

    localparam int BEATS = 8;
    localparam int TO    = 100;
    localparam int W     = 16 * BEATS;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic          link_req = 1'b0;
    logic [15:0]   link_data = 16'h0;
    logic          link_ack;
    logic [W-1:0]  message_out;
    logic          message_valid;
    logic          busy;
    logic          error;

    int checks = 0;
    int failures = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    logic prev_v = 1'b0;
    logic prev_e = 1'b0;
    logic [W-1:0] last_msg = '0;

    always #5 clock = ~clock;

    gpio_message_receiver #(
        .BEATS(BEATS),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock),
        .resetn(resetn),
        .link_req(link_req),
        .link_data(link_data),
        .link_ack(link_ack),
        .message_out(message_out),
        .message_valid(message_valid),
        .busy(busy),
        .error(error)
    );

    task automatic check(input string tag, input logic [W-1:0] obs,
                         input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse bookkeeping and the valid/error exclusivity rules.
    always @(negedge clock) begin
        if (message_valid) valid_cnt++;
        if (error) err_cnt++;
        if (message_valid || error) begin
            check("pulse_rule",
                  W'((message_valid && error) ||
                     (message_valid && prev_v) ||
                     (error && prev_e)),
                  W'(0));
        end
        prev_v = message_valid;
        prev_e = error;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Reference: beat k occupies bits [W-1-16k -: 16].
    function automatic logic [W-1:0] ref_msg(input logic [15:0] b [BEATS]);
        logic [W-1:0] m;
        m = '0;
        for (int k = 0; k < BEATS; k++) begin
            m[16*(BEATS-1-k) +: 16] = b[k];
        end
        return m;
    endfunction

    task automatic raise_req(input logic [15:0] d);
        int n;
        link_data = d;
        tick(1);
        link_req = 1'b1;
        n = 0;
        while (!link_ack && n < 20) begin
            tick(1);
            n++;
        end
        check("ack_rise_latency", W'(n), W'(3));
        check("busy_in_beat", W'(busy), W'(1));
        // Disturb the bus after ack: the captured value must stick.
        link_data = ~d;
    endtask

    task automatic send_beat(input logic [15:0] d, input bit last,
                             input logic [W-1:0] exp);
        int n;
        raise_req(d);
        tick(1);
        link_req = 1'b0;
        n = 0;
        while (link_ack && n < 20) begin
            tick(1);
            n++;
        end
        check("ack_fall_latency", W'(n), W'(3));
        if (last) begin
            check("valid_at_last", W'(message_valid), W'(1));
            check("msg_at_last", message_out, exp);
        end
    endtask

    task automatic send_msg(input logic [15:0] b [BEATS], input int gap);
        logic [W-1:0] exp;
        int v0;
        exp = ref_msg(b);
        v0 = valid_cnt;
        for (int k = 0; k < BEATS; k++) begin
            send_beat(b[k], k == BEATS - 1, exp);
            tick($urandom_range(0, gap));
        end
        tick(2);
        check("valid_count", W'(valid_cnt - v0), W'(1));
        check("msg_hold", message_out, exp);
        check("busy_idle", W'(busy), W'(0));
        last_msg = exp;
    endtask

    task automatic rand_beats(output logic [15:0] b [BEATS]);
        for (int k = 0; k < BEATS; k++) b[k] = 16'($urandom);
    endtask

    initial begin
        logic [15:0] b [BEATS];
        int n;
        int e0;
        int v0;

        // Reset state
        #2;
        check("rst_ack", W'(link_ack), W'(0));
        check("rst_msg", message_out, '0);
        check("rst_valid", W'(message_valid), W'(0));
        check("rst_busy", W'(busy), W'(0));
        check("rst_error", W'(error), W'(0));
        tick(2);
        resetn = 1'b1;
        tick(2);

        // Directed message
        b = '{16'h0000, 16'h0156, 16'h0000, 16'h0C49,
              16'h0000, 16'h730F, 16'h000E, 16'h5597};
        send_msg(b, 0);
        check("plan_msg", message_out,
              128'h00000156_00000C49_0000730F_000E5597);

        // Back-to-back
        for (int k = 0; k < BEATS; k++) b[k] = 16'hFFFF;
        send_msg(b, 0);
        check("all_f", message_out, {W{1'b1}});
        for (int k = 0; k < BEATS; k++) b[k] = 16'h1234;
        send_msg(b, 0);
        check("all_1234", message_out, {BEATS{16'h1234}});

        // Random messages with random inter-beat gaps
        for (int r = 0; r < 3; r++) begin
            rand_beats(b);
            send_msg(b, 6);
        end

        // Timeout in WAIT_HI after three beats
        rand_beats(b);
        e0 = err_cnt;
        v0 = valid_cnt;
        for (int k = 0; k < 3; k++) send_beat(b[k], 1'b0, '0);
        n = 0;
        while (!error && n < 3 * TO) begin
            tick(1);
            n++;
        end
        check("to_hi_error", W'(error), W'(1));
        check("to_hi_window", W'(n >= TO - 5 && n <= TO + 5), W'(1));
        check("to_hi_busy", W'(busy), W'(0));
        check("to_hi_msg", message_out, last_msg);
        tick(2);
        check("to_hi_errcnt", W'(err_cnt - e0), W'(1));
        check("to_hi_novalid", W'(valid_cnt - v0), W'(0));
        rand_beats(b);
        send_msg(b, 3);

        // Timeout in WAIT_LO with req stuck high on beat 2
        rand_beats(b);
        e0 = err_cnt;
        v0 = valid_cnt;
        for (int k = 0; k < 2; k++) send_beat(b[k], 1'b0, '0);
        raise_req(b[2]);
        n = 0;
        while (!error && n < 3 * TO) begin
            tick(1);
            n++;
        end
        check("to_lo_error", W'(error), W'(1));
        check("to_lo_ack", W'(link_ack), W'(0));
        check("to_lo_flush_busy", W'(busy), W'(1));
        tick(20);
        check("flush_ack", W'(link_ack), W'(0));
        check("flush_busy", W'(busy), W'(1));
        link_req = 1'b0;
        tick(5);
        check("flush_exit_busy", W'(busy), W'(0));
        check("to_lo_msg", message_out, last_msg);
        check("to_lo_errcnt", W'(err_cnt - e0), W'(1));
        check("to_lo_novalid", W'(valid_cnt - v0), W'(0));
        rand_beats(b);
        send_msg(b, 3);

        // Reset mid-message while ack is high
        rand_beats(b);
        for (int k = 0; k < 4; k++) send_beat(b[k], 1'b0, '0);
        raise_req(b[4]);
        #2;
        resetn = 1'b0;
        #1;
        check("mid_rst_ack", W'(link_ack), W'(0));
        check("mid_rst_msg", message_out, '0);
        check("mid_rst_valid", W'(message_valid), W'(0));
        check("mid_rst_busy", W'(busy), W'(0));
        check("mid_rst_error", W'(error), W'(0));
        link_req = 1'b0;
        tick(3);
        resetn = 1'b1;
        tick(2);
        rand_beats(b);
        send_msg(b, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
